// File: rtl/cpu_imm_stage.sv
// ---------------------------------------------------------------------------
// cpu_imm_stage
//   Registered, flow-controlled immediate generator for the decode pipeline.
//   Takes instr[31:7] plus a format select, builds the XLEN-wide immediate
//   combinationally, and registers it (with an error flag and sideband tag)
//   into an output register backed by a one-entry skid register. in_ready
//   is derived purely from state, so it never depends on out_ready.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   flush       synchronous flush, drops every buffered beat (and any
//               beat offered in the same cycle)
//   in_valid    input beat valid
//   in_ready    stage can accept a beat (NOT skid_valid)
//   in_data     instr[31:7]
//   in_imm_src  format: 0=I 1=S 2=B 3=U 4=J 5=Z 6=SH 7=reserved
//   in_tag      opaque sideband, carried unchanged
//   out_valid   output beat valid
//   out_ready   consumer accepts the output beat
//   out_imm     extended immediate
//   out_err     reserved format, or 32-bit shamt out of range
//   out_tag     tag of the output beat
// ---------------------------------------------------------------------------
module cpu_imm_stage #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [24:0]      in_data,
  input  logic [2:0]       in_imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_err,
  output logic [TAG_W-1:0] out_tag
);

  // Returns {err, imm}. The signed locals make every size cast a sign
  // extension; the unsigned slices used for Z/SH cast as zero extension.
  function automatic logic [XLEN:0] build_imm(input logic [24:0] d,
                                              input logic [2:0]  src);
    logic signed [11:0] imm_i;
    logic signed [11:0] imm_s;
    logic signed [12:0] imm_b;
    logic signed [31:0] imm_u;
    logic signed [20:0] imm_j;
    logic [XLEN-1:0]    imm;
    logic               err;
    imm_i = d[24:13];
    imm_s = {d[24:18], d[4:0]};
    imm_b = {d[24], d[0], d[23:18], d[4:1], 1'b0};
    imm_u = {d[24:5], 12'b0};
    imm_j = {d[24], d[12:5], d[13], d[23:14], 1'b0};
    imm   = '0;
    err   = 1'b0;
    case (src)
      3'd0: imm = XLEN'(imm_i);
      3'd1: imm = XLEN'(imm_s);
      3'd2: imm = XLEN'(imm_b);
      3'd3: imm = XLEN'(imm_u);
      3'd4: imm = XLEN'(imm_j);
      3'd5: imm = XLEN'(d[12:8]);
      3'd6: begin
        if (XLEN == 64) begin
          imm = XLEN'(d[18:13]);
        end else begin
          // RV32 shifts only have a 5-bit shamt; bit 5 set is illegal.
          imm = XLEN'(d[17:13]);
          err = d[18];
        end
      end
      default: err = 1'b1;
    endcase
    return {err, imm};
  endfunction

  logic [XLEN-1:0]  imm_p0;
  logic             err_p0;
  logic             in_fire;
  logic             skid_valid;
  logic [XLEN-1:0]  skid_imm;
  logic             skid_err;
  logic [TAG_W-1:0] skid_tag;

  // ---- stage 0: combinational immediate build on the input side ----
  always_comb begin
    {err_p0, imm_p0} = build_imm(in_data, in_imm_src);
  end

  assign in_ready = ~skid_valid;
  assign in_fire  = in_valid & in_ready;

  // ---- stage 1: output register with skid backing ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_imm    <= '0;
      out_err    <= 1'b0;
      out_tag    <= '0;
      skid_valid <= 1'b0;
      skid_imm   <= '0;
      skid_err   <= 1'b0;
      skid_tag   <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!out_valid || out_ready) begin
      if (skid_valid) begin
        // in_ready is low while the skid is full, so no new beat competes.
        out_valid  <= 1'b1;
        out_imm    <= skid_imm;
        out_err    <= skid_err;
        out_tag    <= skid_tag;
        skid_valid <= 1'b0;
      end else if (in_fire) begin
        out_valid <= 1'b1;
        out_imm   <= imm_p0;
        out_err   <= err_p0;
        out_tag   <= in_tag;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (in_fire) begin
      skid_valid <= 1'b1;
      skid_imm   <= imm_p0;
      skid_err   <= err_p0;
      skid_tag   <= in_tag;
    end
  end

endmodule

// File: tb/tb_cpu_imm_stage.sv
module tb_cpu_imm_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [24:0] in_data;
  logic [2:0]  in_imm_src;
  logic [7:0]  in_tag;
  logic        out_ready;

  logic        rdy32, vld32, err32;
  logic [31:0] imm32;
  logic [7:0]  tag32;
  logic        rdy64, vld64, err64;
  logic [63:0] imm64;
  logic [7:0]  tag64;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  cpu_imm_stage #(.XLEN(32), .TAG_W(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy32), .in_data(in_data),
    .in_imm_src(in_imm_src), .in_tag(in_tag),
    .out_valid(vld32), .out_ready(out_ready), .out_imm(imm32),
    .out_err(err32), .out_tag(tag32)
  );

  cpu_imm_stage #(.XLEN(64), .TAG_W(8)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy64), .in_data(in_data),
    .in_imm_src(in_imm_src), .in_tag(in_tag),
    .out_valid(vld64), .out_ready(out_ready), .out_imm(imm64),
    .out_err(err64), .out_tag(tag64)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // Reference immediate built with integer arithmetic from the format rules.
  function automatic void ref_imm(input int xlen, input logic [24:0] d,
                                  input logic [2:0] src,
                                  output logic [63:0] imm, output logic err);
    longint dd;
    longint v;
    dd  = longint'({39'd0, d});
    v   = 0;
    err = 1'b0;
    case (src)
      3'd0: begin v = (dd >> 13) & 'hFFF; if (v >= 2048) v -= 4096; end
      3'd1: begin v = ((dd >> 18) & 'h7F) * 32 + (dd & 31); if (v >= 2048) v -= 4096; end
      3'd2: begin
        v = ((dd >> 24) & 1) * 4096 + (dd & 1) * 2048 + ((dd >> 18) & 63) * 32
            + ((dd >> 1) & 15) * 2;
        if (v >= 4096) v -= 8192;
      end
      3'd3: begin
        v = ((dd >> 5) & 'hFFFFF) * 4096;
        if (v >= 64'sh8000_0000) v -= 64'sh1_0000_0000;
      end
      3'd4: begin
        v = ((dd >> 24) & 1) * (1 << 20) + ((dd >> 5) & 255) * 4096
            + ((dd >> 13) & 1) * 2048 + ((dd >> 14) & 1023) * 2;
        if (v >= (1 << 20)) v -= (1 << 21);
      end
      3'd5: v = (dd >> 8) & 31;
      3'd6: begin
        if (xlen == 64) v = (dd >> 13) & 63;
        else begin v = (dd >> 13) & 31; err = d[18]; end
      end
      default: begin v = 0; err = 1'b1; end
    endcase
    imm = v;
    if (xlen == 32) imm = imm & 64'hFFFF_FFFF;
  endfunction

  // Model: a 2-entry FIFO; head is the output beat, in_ready when not full.
  typedef struct packed {
    logic [24:0] d;
    logic [2:0]  src;
    logic [7:0]  tag;
  } beat_t;
  beat_t q[$];

  always @(posedge clk) begin
    if (rst_n) begin
      automatic bit m_rdy = (q.size() < 2);
      automatic bit m_vld = (q.size() > 0);
      if (flush) q.delete();
      else begin
        if (m_vld && out_ready) void'(q.pop_front());
        if (in_valid && m_rdy) q.push_back('{d: in_data, src: in_imm_src, tag: in_tag});
      end
    end
  end

  always @(negedge rst_n) q.delete();

  // Per-cycle compare of both instances against the model.
  always @(negedge clk) begin
    logic [63:0] e_imm;
    logic        e_err;
    chk("rdy32", 64'(rdy32), 64'(q.size() < 2));
    chk("vld32", 64'(vld32), 64'(q.size() > 0));
    chk("rdy64", 64'(rdy64), 64'(q.size() < 2));
    chk("vld64", 64'(vld64), 64'(q.size() > 0));
    if (q.size() > 0) begin
      ref_imm(32, q[0].d, q[0].src, e_imm, e_err);
      chk("imm32", 64'(imm32), e_imm);
      chk("err32", 64'(err32), 64'(e_err));
      chk("tag32", 64'(tag32), 64'(q[0].tag));
      ref_imm(64, q[0].d, q[0].src, e_imm, e_err);
      chk("imm64", imm64, e_imm);
      chk("err64", 64'(err64), 64'(e_err));
      chk("tag64", 64'(tag64), 64'(q[0].tag));
    end
    if (!rst_n) begin
      chk("rst_imm64", imm64, 64'd0);
      chk("rst_tag64", 64'(tag64), 64'd0);
      chk("rst_err32", 64'(err32), 64'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [24:0] d, input logic [2:0] s, input logic [7:0] t);
    in_valid = 1'b1; in_data = d; in_imm_src = s; in_tag = t;
  endtask

  logic [24:0] dvec [6] = '{25'h0000000, 25'h1FFFFFF, 25'h0A5A5A5,
                            25'h1234567, 25'h1800001, 25'h0F0F0F0};

  initial begin
    logic [63:0] mi;
    logic        me;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
    in_imm_src = '0; in_tag = '0; out_ready = 1'b1;

    // Pin the model to hand-computed values.
    ref_imm(32, 25'h1FFE001, 3'd0, mi, me); chk("model_i32", mi, 64'hFFFF_FFFF);
    ref_imm(64, 25'h1000000, 3'd3, mi, me); chk("model_u64", mi, 64'hFFFF_FFFF_8000_0000);
    ref_imm(64, 25'h02468A0, 3'd3, mi, me); chk("model_u64b", mi, 64'h0000_0000_1234_5000);
    ref_imm(32, 25'h0046000, 3'd6, mi, me); chk("model_sh32err", 64'(me), 64'd1);

    repeat (3) step();
    rst_n = 1'b1;
    chk("reset_rdy", 64'(rdy32), 64'd1);
    chk("reset_vld", 64'(vld64), 64'd0);

    // I-format, one-cycle latency.
    offer(25'h1FFE001, 3'd0, 8'h11); step(); in_valid = 1'b0;
    chk("i_vld", 64'(vld32), 64'd1);
    chk("i_imm32", 64'(imm32), 64'hFFFF_FFFF);
    chk("i_imm64", imm64, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("i_err", 64'(err32), 64'd0);
    step();

    // U-format.
    offer(25'h1000000, 3'd3, 8'h21); step();
    chk("u_imm64", imm64, 64'hFFFF_FFFF_8000_0000);
    chk("u_imm32", 64'(imm32), 64'h8000_0000);
    offer(25'h02468A0, 3'd3, 8'h22); step();
    chk("u_imm64b", imm64, 64'h0000_0000_1234_5000);

    // Z and SH.
    offer(25'h0001F00, 3'd5, 8'h31); step();
    chk("z_imm32", 64'(imm32), 64'h1F);
    offer(25'h0046000, 3'd6, 8'h32); step();
    chk("sh32_err", 64'(err32), 64'd1);
    chk("sh64_imm", imm64, 64'd35);
    chk("sh64_err", 64'(err64), 64'd0);
    offer(25'h007E000, 3'd6, 8'h33); step();
    chk("sh64_63", imm64, 64'd63);
    chk("sh64_err63", 64'(err64), 64'd0);

    // Reserved format.
    offer(25'h1ABCDEF, 3'd7, 8'h34); step();
    chk("rsv_imm64", imm64, 64'd0);
    chk("rsv_err32", 64'(err32), 64'd1);
    in_valid = 1'b0; step();

    // All formats over a vector table with intermittent backpressure.
    for (int i = 0; i < 6; i++) begin
      for (int s = 0; s < 8; s++) begin
        offer(dvec[i], 3'(s), 8'(i * 8 + s));
        out_ready = ((i * 8 + s) % 3 != 2);
        step();
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) step();

    // Backpressure: two beats buffered, third waits.
    out_ready = 1'b0;
    offer(25'h0, 3'd0, 8'd1); step();
    offer(25'h0, 3'd0, 8'd2); step();
    chk("bp_rdy_low", 64'(rdy32), 64'd0);
    offer(25'h0, 3'd0, 8'd3); step();
    chk("bp_hold_tag", 64'(tag32), 64'd1);
    chk("bp_still_low", 64'(rdy64), 64'd0);
    out_ready = 1'b1; step();
    chk("bp_tag2", 64'(tag32), 64'd2);
    chk("bp_rdy_back", 64'(rdy32), 64'd1);
    step(); in_valid = 1'b0;
    chk("bp_tag3", 64'(tag64), 64'd3);
    step();
    chk("bp_drained", 64'(vld32), 64'd0);

    // Flush with two beats buffered and a beat offered.
    out_ready = 1'b0;
    offer(25'h1234567, 3'd1, 8'h41); step();
    offer(25'h0A5A5A5, 3'd2, 8'h42); step();
    offer(25'h1FFFFFF, 3'd4, 8'h43); flush = 1'b1; step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_vld", 64'(vld32), 64'd0);
    chk("fl_rdy", 64'(rdy64), 64'd1);
    // Flush while a beat would be accepted into an empty stage.
    offer(25'h0F0F0F0, 3'd0, 8'h44); flush = 1'b1; step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("fl_drop", 64'(vld64), 64'd0);
    repeat (2) step();

    // Asynchronous reset while stalled.
    out_ready = 1'b0;
    offer(25'h1FFE001, 3'd0, 8'h51); step();
    offer(25'h1000000, 3'd3, 8'h52); step();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_vld", 64'(vld32), 64'd0);
    chk("ar_imm", imm64, 64'd0);
    chk("ar_rdy", 64'(rdy32), 64'd1);
    step();
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    offer(25'h0001F00, 3'd5, 8'h61); step(); in_valid = 1'b0;
    repeat (3) step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
